// File: rtl/qar_spi_arb_if.sv
// qar_spi_arb_if: requester handshake and qar_spi register-bus bundle.
//   master : arbiter side (consumes requests and rdata, drives grants, responses and bus strobes)
//   slave  : environment side (requesters plus the qar_spi register file)
//   req_valid/req_data/req_last : per-requester byte stream, byte i at [8i+7:8i]
//   req_ready/rsp_valid/rsp_data/err/grant : per-requester handshake and status
//   bus_write/bus_read/addr_word/wdata/rdata : qar_spi register bus
interface qar_spi_arb_if #(
    parameter int unsigned N_REQ = 4
) ();
    logic [N_REQ-1:0]   req_valid;
    logic [8*N_REQ-1:0] req_data;
    logic [N_REQ-1:0]   req_last;
    logic [N_REQ-1:0]   req_ready;
    logic [N_REQ-1:0]   rsp_valid;
    logic [7:0]         rsp_data;
    logic [N_REQ-1:0]   err;
    logic [N_REQ-1:0]   grant;
    logic               bus_write;
    logic               bus_read;
    logic [5:0]         addr_word;
    logic [31:0]        wdata;
    logic [31:0]        rdata;

    modport master (
        input  req_valid, req_data, req_last, rdata,
        output req_ready, rsp_valid, rsp_data, err, grant,
               bus_write, bus_read, addr_word, wdata
    );

    modport slave (
        output req_valid, req_data, req_last, rdata,
        input  req_ready, rsp_valid, rsp_data, err, grant,
               bus_write, bus_read, addr_word, wdata
    );
endinterface

// File: rtl/qar_spi_arb.sv
// qar_spi_arb: round-robin arbiter and transaction sequencer that shares one
// qar_spi peripheral between N_REQ byte-stream requesters.
//   clk, rst : clock and asynchronous active-high reset
//   bus      : qar_spi_arb_if.master
//              requester side: req_valid/req_data/req_last in, req_ready,
//              rsp_valid/rsp_data, err, grant out
//              peripheral side: bus_write/bus_read/addr_word/wdata out, rdata in
// grant and err are registered; req_ready, rsp_* and the bus strobes decode
// combinationally from the current state so each strobe lines up with its
// state cycle.
module qar_spi_arb #(
    parameter int unsigned N_REQ      = 4,
    parameter logic [31:0] CLKDIV     = 32'd4,
    parameter logic [15:0] POLL_LIMIT = 16'd1000
) (
    input  logic           clk,
    input  logic           rst,
    qar_spi_arb_if.master  bus
);

    localparam int unsigned IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int unsigned CNT_W = 16;

    localparam logic [5:0] A_CTRL   = 6'h0;
    localparam logic [5:0] A_STATUS = 6'h1;
    localparam logic [5:0] A_CLKDIV = 6'h2;
    localparam logic [5:0] A_TXDATA = 6'h3;
    localparam logic [5:0] A_RXDATA = 6'h4;
    localparam logic [5:0] A_CSSEL  = 6'h5;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SET_DIV,
        S_SET_CS,
        S_ENABLE,
        S_WAIT_TX,
        S_POLL,
        S_READ_RX,
        S_RELEASE
    } state_t;

    state_t             state, state_nxt;
    logic [IDX_W-1:0]   owner, owner_nxt;
    logic [IDX_W-1:0]   rr, rr_nxt;
    logic               last_q, last_nxt;
    logic [CNT_W-1:0]   poll_cnt, poll_cnt_nxt;
    logic [N_REQ-1:0]   grant_q, grant_nxt;
    logic [N_REQ-1:0]   err_q, err_nxt;

    logic               pick_found;
    logic [IDX_W-1:0]   pick_idx;
    logic [31:0]        cand;
    logic [7:0]         tx_byte;
    logic [CNT_W:0]     poll_inc;
    logic               poll_reached;
    logic               unused_rdata;

    // Only the busy flag and the RX byte are consumed from read data.
    assign unused_rdata = ^bus.rdata[31:8];

    assign bus.grant = grant_q;
    assign bus.err   = err_q;

    // Owner's TX byte lane.
    assign tx_byte = bus.req_data[{owner, 3'b000} +: 8];

    // Poll count including the current poll; one extra bit so the compare cannot wrap.
    assign poll_inc     = (CNT_W+1)'(poll_cnt) + (CNT_W+1)'(1);
    assign poll_reached = (poll_inc >= (CNT_W+1)'(POLL_LIMIT));

    // First valid requester at or after rr, wrapping.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        cand       = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            cand = (32'(rr) + 32'(i)) % 32'(N_REQ);
            if (!pick_found && bus.req_valid[IDX_W'(cand)]) begin
                pick_found = 1'b1;
                pick_idx   = IDX_W'(cand);
            end
        end
    end

    // State and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            owner    <= '0;
            rr       <= '0;
            last_q   <= 1'b0;
            poll_cnt <= '0;
            grant_q  <= '0;
            err_q    <= '0;
        end else begin
            state    <= state_nxt;
            owner    <= owner_nxt;
            rr       <= rr_nxt;
            last_q   <= last_nxt;
            poll_cnt <= poll_cnt_nxt;
            grant_q  <= grant_nxt;
            err_q    <= err_nxt;
        end
    end

    // Next-state and combinational bus/handshake decode.
    always_comb begin
        state_nxt     = state;
        owner_nxt     = owner;
        rr_nxt        = rr;
        last_nxt      = last_q;
        poll_cnt_nxt  = poll_cnt;
        grant_nxt     = grant_q;
        err_nxt       = '0;
        bus.req_ready = '0;
        bus.rsp_valid = '0;
        bus.rsp_data  = '0;
        bus.bus_write = 1'b0;
        bus.bus_read  = 1'b0;
        bus.addr_word = '0;
        bus.wdata     = '0;

        case (state)
            S_IDLE: begin
                if (pick_found) begin
                    owner_nxt           = pick_idx;
                    grant_nxt           = '0;
                    grant_nxt[pick_idx] = 1'b1;
                    rr_nxt              = (pick_idx == IDX_W'(N_REQ - 1)) ? '0
                                                                         : pick_idx + IDX_W'(1);
                    state_nxt           = S_SET_DIV;
                end
            end

            S_SET_DIV: begin
                bus.bus_write = 1'b1;
                bus.addr_word = A_CLKDIV;
                bus.wdata     = CLKDIV;
                state_nxt     = S_SET_CS;
            end

            S_SET_CS: begin
                bus.bus_write = 1'b1;
                bus.addr_word = A_CSSEL;
                bus.wdata     = 32'(owner);
                state_nxt     = S_ENABLE;
            end

            S_ENABLE: begin
                bus.bus_write = 1'b1;
                bus.addr_word = A_CTRL;
                bus.wdata     = 32'd1;
                state_nxt     = S_WAIT_TX;
            end

            // Owner may stall here indefinitely; the grant is held.
            S_WAIT_TX: begin
                bus.req_ready[owner] = 1'b1;
                if (bus.req_valid[owner]) begin
                    bus.bus_write = 1'b1;
                    bus.addr_word = A_TXDATA;
                    bus.wdata     = {24'b0, tx_byte};
                    last_nxt      = bus.req_last[owner];
                    poll_cnt_nxt  = '0;
                    state_nxt     = S_POLL;
                end
            end

            // Idle status wins over timeout when both land on the same poll.
            S_POLL: begin
                bus.bus_read  = 1'b1;
                bus.addr_word = A_STATUS;
                poll_cnt_nxt  = poll_reached ? POLL_LIMIT : poll_inc[CNT_W-1:0];
                if (!bus.rdata[0]) begin
                    state_nxt = S_READ_RX;
                end else if (poll_reached) begin
                    err_nxt[owner] = 1'b1;
                    state_nxt      = S_RELEASE;
                end
            end

            S_READ_RX: begin
                bus.bus_read         = 1'b1;
                bus.addr_word        = A_RXDATA;
                bus.rsp_valid[owner] = 1'b1;
                bus.rsp_data         = bus.rdata[7:0];
                state_nxt            = last_q ? S_RELEASE : S_WAIT_TX;
            end

            S_RELEASE: begin
                bus.bus_write = 1'b1;
                bus.addr_word = A_CTRL;
                bus.wdata     = 32'd0;
                grant_nxt     = '0;
                state_nxt     = S_IDLE;
            end

            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_qar_spi_arb.sv
// tb_qar_spi_arb: directed bench for qar_spi_arb with a behavioural qar_spi
// register model, a bus/response scoreboard and per-cycle invariant checks.
module tb_qar_spi_arb;

    localparam int unsigned N_REQ = 4;
    localparam int unsigned RW    = $clog2(N_REQ);
    localparam int unsigned DW    = $clog2(8 * N_REQ);

    typedef struct packed {
        logic        wr;
        logic [5:0]  addr;
        logic [31:0] data;
    } bus_item_t;

    logic clk;
    logic rst;

    qar_spi_arb_if #(.N_REQ(N_REQ)) bus ();

    qar_spi_arb #(
        .N_REQ      (N_REQ),
        .CLKDIV     (32'd4),
        .POLL_LIMIT (16'd8)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int passes = 0;
    int fails  = 0;

    bus_item_t   exp_bus[$];
    logic [11:0] exp_rsp[$];
    bit          sb_en;
    int          err_pulses = 0;
    logic [3:0]  last_err;

    // Peripheral model: STATUS busy for cfg_busy reads after each TX write,
    // RX byte = TX byte ^ 0x5A.
    int          cfg_busy;
    logic [15:0] busy_left;
    logic [7:0]  rx_byte;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_left <= '0;
            rx_byte   <= '0;
        end else if (bus.bus_write && bus.addr_word == 6'd3) begin
            busy_left <= 16'(cfg_busy);
            rx_byte   <= bus.wdata[7:0] ^ 8'h5A;
        end else if (bus.bus_read && bus.addr_word == 6'd1 && busy_left != 0) begin
            busy_left <= busy_left - 16'd1;
        end
    end

    always_comb begin
        bus.rdata = '0;
        if (bus.bus_read) begin
            if (bus.addr_word == 6'd1) bus.rdata = {31'b0, busy_left != 16'd0};
            else if (bus.addr_word == 6'd4) bus.rdata = {24'b0, rx_byte};
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Monitor: invariants every cycle, scoreboard pops on bus/response activity.
    always @(negedge clk) begin
        #2;
        if (!rst) begin
            chk("bus_exclusive", 64'(bus.bus_write & bus.bus_read), 64'd0);
            chk("grant_onehot0", 64'($onehot0(bus.grant)), 64'd1);
            if (bus.err != '0) begin
                err_pulses++;
                last_err = bus.err;
            end
            if (sb_en) begin
                if (bus.bus_write || bus.bus_read) begin
                    if (exp_bus.size() == 0) begin
                        chk("bus_unexpected", 64'({bus.bus_write, bus.bus_read, bus.addr_word}), 64'd0);
                    end else begin
                        bus_item_t e;
                        e = exp_bus.pop_front();
                        chk("bus_seq",
                            64'({bus.bus_write, bus.addr_word, bus.bus_write ? bus.wdata : 32'd0}),
                            64'({e.wr, e.addr, e.wr ? e.data : 32'd0}));
                    end
                end
                if (bus.rsp_valid != '0) begin
                    if (exp_rsp.size() == 0) begin
                        chk("rsp_unexpected", 64'({bus.rsp_valid, bus.rsp_data}), 64'd0);
                    end else begin
                        logic [11:0] r;
                        r = exp_rsp.pop_front();
                        chk("rsp", 64'({bus.rsp_valid, bus.rsp_data}), 64'(r));
                    end
                end
            end
        end
    end

    task automatic push_w(input logic [5:0] a, input logic [31:0] d);
        bus_item_t e;
        e.wr = 1'b1; e.addr = a; e.data = d;
        exp_bus.push_back(e);
    endtask

    task automatic push_r(input logic [5:0] a);
        bus_item_t e;
        e.wr = 1'b0; e.addr = a; e.data = '0;
        exp_bus.push_back(e);
    endtask

    // Expected bus traffic and responses for one complete grant.
    task automatic push_txn(input int owner, input int n, input logic [7:0] b [4],
                            input int busy, input bit timeout);
        push_w(6'd2, 32'd4);
        push_w(6'd5, 32'(owner));
        push_w(6'd0, 32'd1);
        for (int k = 0; k < n; k++) begin
            push_w(6'd3, {24'b0, b[k]});
            if (timeout) begin
                for (int p = 0; p < 8; p++) push_r(6'd1);
            end else begin
                for (int p = 0; p < busy; p++) push_r(6'd1);
                push_r(6'd1);
                push_r(6'd4);
                exp_rsp.push_back({4'b0001 << owner, b[k] ^ 8'h5A});
            end
        end
        push_w(6'd0, 32'd0);
    endtask

    // Present n bytes from requester idx; lat = negedges from first valid to first ready.
    task automatic req_stream(input int idx, input int n, input logic [7:0] b [4], output int lat);
        int waited;
        lat = -1;
        for (int k = 0; k < n; k++) begin
            waited = 0;
            bus.req_valid[RW'(idx)]        = 1'b1;
            bus.req_data[DW'(8 * idx) +: 8] = b[k];
            bus.req_last[RW'(idx)]         = (k == n - 1);
            while (!bus.req_ready[RW'(idx)] && waited < 400) begin
                @(negedge clk);
                waited++;
            end
            if (!bus.req_ready[RW'(idx)]) begin
                chk("ready_timeout", 64'(bus.req_ready), 64'(4'b0001 << idx));
                bus.req_valid[RW'(idx)] = 1'b0;
                return;
            end
            if (k == 0) begin
                lat = waited;
                chk("grant_owner", 64'(bus.grant), 64'(4'b0001 << idx));
            end
            @(posedge clk);
            @(negedge clk);
        end
        bus.req_valid[RW'(idx)] = 1'b0;
        bus.req_last[RW'(idx)]  = 1'b0;
    endtask

    task automatic wait_done();
        int w;
        w = 0;
        while (!(exp_bus.size() == 0 && bus.grant == '0) && w < 600) begin
            @(negedge clk);
            w++;
        end
        chk("drain", 64'({bus.grant, 16'(exp_bus.size())}), 64'd0);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk(tag, 64'({bus.grant, bus.req_ready, bus.rsp_valid, bus.err,
                      bus.bus_write, bus.bus_read}), 64'd0);
        chk({tag, "_bus"}, 64'({bus.addr_word, bus.wdata, bus.rsp_data}), 64'd0);
    endtask

    logic [7:0] ba [4];
    logic [7:0] bb [4];
    int         lat_a;
    int         lat_b;
    int         errs0;
    int         w;

    initial begin
        rst           = 1'b1;
        sb_en         = 1'b0;
        cfg_busy      = 0;
        last_err      = '0;
        bus.req_valid = '0;
        bus.req_data  = '0;
        bus.req_last  = '0;
        repeat (2) @(negedge clk);
        #1;
        chk_reset_outputs("reset_state");
        rst = 1'b0;
        @(negedge clk);
        chk_reset_outputs("idle_after_reset");
        sb_en = 1'b1;

        // Single byte from requester 0, three busy polls.
        cfg_busy = 3;
        ba = '{8'hA5, 8'h00, 8'h00, 8'h00};
        push_txn(0, 1, ba, 3, 1'b0);
        req_stream(0, 1, ba, lat_a);
        chk("first_ready_latency", 64'(lat_a), 64'd4);
        wait_done();

        // Requesters 1 and 3 together with rr=1: 1 first, then 3.
        cfg_busy = 1;
        ba = '{8'h11, 8'h00, 8'h00, 8'h00};
        bb = '{8'h33, 8'h00, 8'h00, 8'h00};
        push_txn(1, 1, ba, 1, 1'b0);
        push_txn(3, 1, bb, 1, 1'b0);
        fork
            req_stream(1, 1, ba, lat_a);
            req_stream(3, 1, bb, lat_b);
        join
        chk("rr_first_latency", 64'(lat_a), 64'd4);
        chk("rr_second_latency", 64'(lat_b), 64'd13);
        wait_done();

        // rr wrapped to 0: simultaneous 0/1 grants 0 first.
        ba = '{8'h40, 8'h00, 8'h00, 8'h00};
        bb = '{8'h41, 8'h00, 8'h00, 8'h00};
        push_txn(0, 1, ba, 1, 1'b0);
        push_txn(1, 1, bb, 1, 1'b0);
        fork
            req_stream(0, 1, ba, lat_a);
            req_stream(1, 1, bb, lat_b);
        join
        chk("wrap_first_latency", 64'(lat_a), 64'd4);
        chk("wrap_second_latency", 64'(lat_b), 64'd13);
        wait_done();

        // Three-byte burst from 2 while 0 waits; minimum one poll per byte.
        cfg_busy = 0;
        ba = '{8'h01, 8'h02, 8'h03, 8'h00};
        bb = '{8'h7E, 8'h00, 8'h00, 8'h00};
        push_txn(2, 3, ba, 0, 1'b0);
        push_txn(0, 1, bb, 0, 1'b0);
        fork
            req_stream(2, 3, ba, lat_a);
            req_stream(0, 1, bb, lat_b);
        join
        chk("burst_first_latency", 64'(lat_a), 64'd4);
        chk("burst_waiter_latency", 64'(lat_b), 64'd18);
        wait_done();

        // STATUS stuck busy: 8 polls, one err pulse, no response.
        cfg_busy = 1000;
        errs0 = err_pulses;
        ba = '{8'hC3, 8'h00, 8'h00, 8'h00};
        push_txn(3, 1, ba, 0, 1'b1);
        req_stream(3, 1, ba, lat_a);
        chk("timeout_ready_latency", 64'(lat_a), 64'd4);
        wait_done();
        chk("err_pulse_count", 64'(err_pulses - errs0), 64'd1);
        chk("err_owner", 64'(last_err), 64'b1000);

        // Reset during POLL, then a fresh grant restarts from SET_DIV.
        sb_en = 1'b0;
        ba = '{8'h3C, 8'h00, 8'h00, 8'h00};
        req_stream(1, 1, ba, lat_a);
        chk("pre_reset_latency", 64'(lat_a), 64'd4);
        w = 0;
        while (!(bus.bus_read && bus.addr_word == 6'd1) && w < 50) begin
            @(negedge clk);
            w++;
        end
        chk("poll_before_reset", 64'({bus.bus_read, bus.addr_word}), 64'({1'b1, 6'd1}));
        rst = 1'b1;
        #1;
        chk_reset_outputs("mid_poll_reset");
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk_reset_outputs("post_reset_idle");
        sb_en = 1'b1;
        cfg_busy = 2;
        push_txn(1, 1, ba, 2, 1'b0);
        req_stream(1, 1, ba, lat_a);
        chk("restart_latency", 64'(lat_a), 64'd4);
        wait_done();

        repeat (3) @(negedge clk);
        chk("bus_queue_empty", 64'(exp_bus.size()), 64'd0);
        chk("rsp_queue_empty", 64'(exp_rsp.size()), 64'd0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
